// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: HS/VS/DE, pixel coordinates and line/frame markers.
// Raster starts only after the PLL lock has been stable for a fixed settle period.
//
// Ports:
//   clk          pixel clock, the only clock
//   rst_n        synchronous active-low reset
//   pll_lock     PLL lock indication (asynchronous, synchronized here)
//   pix_req      pixel request, leads lcd_de by PREFETCH clocks
//   lcd_hs       horizontal sync (polarity HS_POL)
//   lcd_vs       vertical sync (polarity VS_POL)
//   lcd_de       data enable
//   pix_x        column of the current DE pixel, 0 when lcd_de=0
//   pix_y        row of the current DE pixel, 0 when lcd_de=0
//   line_start   pulse with the first DE pixel of each line
//   frame_start  pulse with pixel (0,0) of each frame
//   running      high while the raster is running
module lcd_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 13,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 29,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int PREFETCH  = 2,
  parameter int LOCK_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_lock,
  output logic        pix_req,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = $clog2(LOCK_WAIT + 1);

  localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
  localparam logic [10:0] H_HS0_L  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_HS1_L  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST_L = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_VS0_L  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_VS1_L  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  // One pixel slot of the output pipeline; hs/vs are "active" flags,
  // polarity is applied only at the pins.
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [10:0] x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
  } px_t;

  localparam px_t IDLE = '{
    de: 1'b0, hs: 1'b0, vs: 1'b0,
    x: 11'd0, y: 10'd0,
    ls: 1'b0, fs: 1'b0
  };

  logic          lock_m;
  logic          lock_s;
  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_nx;
  logic          run_ok;
  logic [10:0]   h_cnt;
  logic [9:0]    v_cnt;
  logic          h_last;
  logic          v_last;
  px_t           s0;
  px_t           s1;
  px_t           pipe [PREFETCH];
  px_t           o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    settle_nx = '0;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) state_nx = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end else if (settle_cnt == SET_LAST) begin
          state_nx = RUN;
        end else begin
          settle_nx = settle_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) state_nx = WAIT_LOCK;
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  // Lock loss flushes counters and pipeline on the same edge that
  // leaves RUN, so a relock always restarts at (0,0).
  assign run_ok = (state == RUN) && lock_s;
  assign h_last = (h_cnt == H_LAST_L);
  assign v_last = (v_cnt == V_LAST_L);

  always_ff @(posedge clk) begin
    if (!rst_n || !run_ok) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    s0    = IDLE;
    s0.de = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    s0.hs = (h_cnt >= H_HS0_L) && (h_cnt < H_HS1_L);
    s0.vs = (v_cnt >= V_VS0_L) && (v_cnt < V_VS1_L);
    s0.x  = s0.de ? h_cnt : '0;
    s0.y  = s0.de ? v_cnt : '0;
    s0.ls = s0.de && (h_cnt == '0);
    s0.fs = s0.de && (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !run_ok) begin
      s1 <= IDLE;
    end else begin
      s1 <= s0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !run_ok) begin
      for (int i = 0; i < PREFETCH; i++) pipe[i] <= IDLE;
    end else begin
      pipe[0] <= s1;
      for (int i = 1; i < PREFETCH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign o           = pipe[PREFETCH-1];
  assign pix_req     = s1.de;
  assign lcd_de      = o.de;
  assign lcd_hs      = o.hs ? HS_POL : ~HS_POL;
  assign lcd_vs      = o.vs ? VS_POL : ~VS_POL;
  assign pix_x       = o.x;
  assign pix_y       = o.y;
  assign line_start  = o.ls;
  assign frame_start = o.fs;
  assign running     = (state == RUN);

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Raster timing generator for the LCD output path, clocked by the pixel clock from the LCD PLL and gated by that PLL's lock indication. It produces HS/VS/DE, pixel coordinates and frame/line markers for the LCD pins. It also produces a pixel request that leads DE by a fixed number of cycles, so the upstream frame-buffer read path can return pixel data aligned to DE.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch, in clocks
- H_SYNC, 128, HS pulse width, in clocks
- H_BP, 88, horizontal back porch, in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch, in lines
- V_SYNC, 3, VS pulse width, in lines
- V_BP, 29, vertical back porch, in lines
- HS_POL, 0, HS active level (0 = active-low)
- VS_POL, 0, VS active level (0 = active-low)
- PREFETCH, 2, clocks by which pix_req leads lcd_de; legal range 1..8
- LOCK_WAIT, 1024, consecutive synchronized-lock clocks required before raster starts
- clk  in  1  pixel clock (PLL CLKOUT); the only clock
- rst_n  in  1  synchronous, active-low reset
- pll_lock  in  1  PLL lock; treated as asynchronous
- pix_req  out  1  request for the next pixel; leads lcd_de by PREFETCH clocks
- lcd_hs  out  1  horizontal sync
- lcd_vs  out  1  vertical sync
- lcd_de  out  1  data enable
- pix_x  out  11  column of current DE pixel; 0 when lcd_de=0
- pix_y  out  10  row of current DE pixel; 0 when lcd_de=0
- line_start  out  1  1-clock pulse with the first DE pixel of each line
- frame_start  out  1  1-clock pulse with pixel (0,0) of each frame
- running  out  1  high while state is RUN

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- pll_lock passes through a 2-flop synchronizer to give lock_s.
- FSM states:
  - WAIT_LOCK: entered on reset; exits to SETTLE when lock_s=1.
  - SETTLE: settle counter counts consecutive lock_s=1 clocks. lock_s=0 returns to WAIT_LOCK and clears the counter. When the counter reaches LOCK_WAIT-1, go to RUN.
  - RUN: raster counters h_cnt and v_cnt are active. lock_s=0 returns to WAIT_LOCK on the next clock.
- Raster counters:
  - h_cnt counts 0..H_TOTAL-1, then wraps.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1.
  - Both counters are held at 0 outside RUN.
- Stage-0 predicates, evaluated on the counters:
  - act = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hs_a = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_a = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. VS changes only at h_cnt=0.
- pix_req = registered act.
- lcd_de, lcd_hs, lcd_vs, pix_x, pix_y, line_start and frame_start come from a PREFETCH-deep shift pipeline fed by the same registered stage. This fixes their alignment exactly PREFETCH clocks after pix_req.
- Sync polarity: lcd_hs = HS_POL when hs_a, else !HS_POL. lcd_vs uses VS_POL the same way.
- Leaving RUN (lock loss), in the same clock:
  - the pipeline is flushed to inactive values;
  - no partial frame is resumed.
  - After relock, the raster restarts at (0,0) after the full LOCK_WAIT.
- Width rules: counters are 11 bits (h) and 10 bits (v). Parameters must satisfy H_TOTAL ≤ 2048, V_TOTAL ≤ 1024 and PREFETCH < H_FP+H_SYNC+H_BP; these are not checked in RTL.

## Timing
- Reset (rst_n=0 at a clock edge) produces, on the next clock:
  - state WAIT_LOCK; settle counter and raster counters 0;
  - pix_req=0, lcd_de=0, pix_x=0, pix_y=0, line_start=0, frame_start=0, running=0;
  - lcd_hs=!HS_POL, lcd_vs=!VS_POL;
  - synchronizer flops cleared.
- Latency: pll_lock rising to running=1 takes 2 synchronizer clocks + LOCK_WAIT clocks (±1 for input sampling phase).
- Pipeline latency:
  - The first RUN clock has h_cnt=0 and v_cnt=0.
  - pix_req rises 1 clock later.
  - lcd_de and frame_start rise PREFETCH clocks after pix_req.
- Cadence: each line gives H_ACTIVE consecutive DE clocks followed by H_TOTAL-H_ACTIVE idle clocks. The frame period is H_TOTAL*V_TOTAL clocks.
- Simultaneous events:
  - Reset has priority over lock loss, which has priority over counter advance.
  - At frame wrap, frame_start and line_start assert together.
- Reset mid-frame: outputs reach their reset values on the next clock, regardless of pipeline contents.

## Test plan
- Reset and lock-up, with LOCK_WAIT=16: hold rst_n=0, then release with pll_lock=1 → all outputs hold reset values until running=1 at clock 18±1; pix_req rises 1 clock later; lcd_de and frame_start rise PREFETCH=2 clocks after pix_req, with pix_x=0 and pix_y=0.
- Default raster: run 2 frames → exactly 800 DE clocks per line and 480 DE lines per frame.
  - HS low for 128 clocks, starting 840 clocks after the line's first DE.
  - VS low for 3 lines, starting at line 493.
  - frame_start period 554400 clocks; pix_x goes 0..799 and pix_y goes 0..479.
- Prefetch alignment: sweep PREFETCH ∈ {1,4,8} → for every clock, lcd_de(t) equals pix_req(t−PREFETCH), and coordinates increment only while DE is high.
- Lock glitch in SETTLE: drop pll_lock for 3 clocks at settle count 10 → FSM returns to WAIT_LOCK and running is delayed by a full new LOCK_WAIT.
- Lock loss mid-frame at line 200: deassert pll_lock → within 3 clocks, lcd_de=0, pix_req=0 and syncs go inactive; after relock, the first frame_start coincides with pix_x=0 and pix_y=0.
- Polarity and small raster: HS_POL=1, VS_POL=1, 8×4 active, all porches 2 → HS high for 2 clocks per 14-clock line; VS high for 2 lines per 10-line frame; frame period 140 clocks.
